// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, valid/ack handshake
// with a one-cycle framing-error pulse and a sticky overrun flag.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronized input
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling the 8 data bits, LSB first
// STOP  | sampling the stop bit, then delivering the byte or flagging an error
module uart_receiver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ack,
    output logic [7:0] RX_DATA,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_nx;
    logic            rx_m;
    logic            rx_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [3:0]      samp_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic            start_entry;
    logic            samp_pt;
    logic            bit_clr;
    logic            shift_en;
    logic            load_en;
    logic            ferr_set;

    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!rx_s) state_nx = START;
            START: if (tick && samp_cnt == 4'd7) state_nx = rx_s ? IDLE : DATA;
            DATA:  if (tick && samp_cnt == 4'd15 && bit_cnt == 3'd7) state_nx = STOP;
            STOP:  if (tick && samp_cnt == 4'd15) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_entry = 1'b0;
        samp_pt     = 1'b0;
        bit_clr     = 1'b0;
        shift_en    = 1'b0;
        load_en     = 1'b0;
        ferr_set    = 1'b0;
        rx_busy     = (state != IDLE);
        case (state)
            IDLE:  start_entry = !rx_s;
            START: begin
                samp_pt = tick && (samp_cnt == 4'd7);
                bit_clr = samp_pt;
            end
            DATA: begin
                samp_pt  = tick && (samp_cnt == 4'd15);
                shift_en = samp_pt;
            end
            STOP: begin
                samp_pt  = tick && (samp_cnt == 4'd15);
                load_en  = samp_pt && rx_s;
                ferr_set = samp_pt && !rx_s;
            end
            default: ;
        endcase
    end

    // Synchronizer idles high so a reset release never looks like a start bit.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            tick_cnt  <= '0;
            samp_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= UART_RX;
            rx_s      <= rx_m;
            frame_err <= ferr_set;

            if (start_entry || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            if (start_entry || samp_pt) begin
                samp_cnt <= 4'd0;
            end else if (tick) begin
                samp_cnt <= samp_cnt + 4'd1;
            end

            if (bit_clr) begin
                bit_cnt <= 3'd0;
            end else if (shift_en && bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // A load in the same cycle as an ack keeps the new byte valid and drops overrun.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            RX_DATA  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (load_en) begin
            RX_DATA  <= shreg;
            rx_valid <= 1'b1;
            overrun  <= rx_ack ? 1'b0 : (overrun | rx_valid);
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for 8N1 frames: idle high, one low start bit, 8 data bits LSB first, one high stop bit. It is the receive-side counterpart of the transmit path and sits between the board `UART_RX` pin and the CPU's memory-mapped UART peripheral registers. It oversamples the line at 16x the baud rate and delivers each byte with a valid/acknowledge handshake. It also flags framing errors and overruns.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `DIV` (localparam), CLK_FREQ/(BAUD*16) truncated, sysclk cycles per oversample tick; must be ≥ 2

- `sysclk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `UART_RX`  in  1  asynchronous serial input
- `rx_ack`  in  1  consumer has taken `RX_DATA`; clears `rx_valid`
- `RX_DATA`  out  8  last correctly framed byte
- `rx_valid`  out  1  `RX_DATA` holds an unread byte
- `rx_busy`  out  1  high while the FSM is not in IDLE
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  sticky: a byte arrived while `rx_valid` was high; cleared by `rx_ack` or reset

## Operation
- Input sync: `UART_RX` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM uses only the second flop (`rx_s`).
- Tick generator: `tick_cnt` counts 0..DIV-1 and `tick` is high when `tick_cnt == DIV-1`. It is cleared on entry to START.
- `samp_cnt` is 4 bits and increments on each tick. It is cleared on entry to START and after every sample point.
- `bit_cnt` is 3 bits, 0..7.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: when `rx_s == 0`, go to START and clear `tick_cnt` and `samp_cnt`.
  - START: on tick with `samp_cnt == 7` (mid start bit):
    - If `rx_s == 0`, go to DATA, clear `samp_cnt` and `bit_cnt`.
    - Otherwise treat it as a glitch and return to IDLE. No flags change.
  - DATA: on tick with `samp_cnt == 15`, shift `rx_s` into `shreg[7]` with a right shift (LSB first).
    - When `bit_cnt == 7`, go to STOP. Otherwise increment `bit_cnt`.
  - STOP: on tick with `samp_cnt == 15`, go to IDLE and act on the sampled stop bit:
    - `rx_s == 1`: load `RX_DATA ← shreg` and set `rx_valid`. If `rx_valid` was already high and `rx_ack` is low in the same cycle, also set `overrun`; the new byte overwrites the old one.
    - `rx_s == 0`: pulse `frame_err` for one cycle. `RX_DATA`, `rx_valid` and `overrun` are unchanged.
- The FSM returns to IDLE at mid stop bit, so a start bit that immediately follows is caught.
- Handshake:
  - `rx_ack` high clears `rx_valid` and `overrun` on the next edge.
  - Load wins over ack: if a load and `rx_ack` occur in the same cycle, `rx_valid` ends at 1 and `overrun` ends at 0.
  - `rx_ack` while `rx_valid` is low has no effect.
- A frame has no length limit on line idle; the FSM stays in IDLE while `rx_s == 1`.

## Timing
- Reset values: `RX_DATA = 8'h00`, `rx_valid = 0`, `rx_busy = 0`, `frame_err = 0`, `overrun = 0`, FSM in IDLE, all counters 0, `shreg = 0`.
- Reset is sampled only on the `sysclk` edge. Reset asserted mid-frame aborts the frame immediately and produces no flags.
- The line is sampled at 8·DIV cycles after START entry, then every 16·DIV cycles.
- Latency from the `UART_RX` falling edge to `rx_valid` rising is 3 + 152·DIV cycles. The bench tolerance is ±2 cycles.
- `rx_busy` rises 3 cycles (±1) after the falling edge and falls on the cycle `rx_valid` or `frame_err` asserts.
- `frame_err` is exactly 1 cycle wide. `rx_valid` holds until acked.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: CLK_FREQ=1_600_000 and BAUD=10_000, giving DIV=10 and a bit time of 160 cycles.

1. Reset, then a frame carrying 8'hA5 → `rx_valid` rises 1523±2 cycles after the start edge, `RX_DATA=8'hA5`. `rx_ack` clears `rx_valid` next cycle. `overrun=0`.
2. Frames 8'h00, 8'hFF and 8'h5A sent back-to-back with no idle gap, each acked within 10 cycles → three `rx_valid` pulses, data correct, no `frame_err`.
3. Frame 8'h3C with the stop bit driven low → one-cycle `frame_err`, `rx_valid` stays 0, `RX_DATA` keeps its previous value.
4. A 40-cycle low glitch on idle `UART_RX` → `rx_busy` pulses, then returns to IDLE. No `rx_valid` and no `frame_err`.
5. Two frames (8'h11 then 8'h22) with no ack in between → `RX_DATA=8'h22`, `overrun=1`. Then `rx_ack` → `rx_valid=0`, `overrun=0`.
6. `reset` asserted low during data bit 4 of a frame, released after 5 cycles, then a clean frame 8'hC3 → all outputs at reset values, after which `RX_DATA=8'hC3` and `rx_valid=1`.
